// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction fetch unit and the load/store unit.
// One transaction in flight; LSU has priority, bounded by a starvation limit that forces IFU through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                proto_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    state_t           state;
    logic             owner_lsu;
    logic [CNT_W-1:0] starve_cnt;
    logic             in_idle;
    logic             grant_lsu;
    logic             grant_ifu;

    // Grant is decided purely from registered state and requester valids,
    // so mem_req_ready never reaches the requester ready signals.
    always_comb begin
        in_idle   = (state == IDLE) && !rst;
        grant_lsu = in_idle && lsu_req_valid && !(ifu_req_valid && (starve_cnt == LIMIT));
        grant_ifu = in_idle && ifu_req_valid && !grant_lsu;
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = (state == ISSUE);
    assign busy           = (state != IDLE);
    assign ifu_resp_valid = (state == WAIT_RESP) && mem_resp_valid && !owner_lsu;
    assign lsu_resp_valid = (state == WAIT_RESP) && mem_resp_valid && owner_lsu;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_lsu  <= 1'b0;
            starve_cnt <= '0;
            proto_err  <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            // A response is only legal while a transaction is waiting for it.
            if (mem_resp_valid && (state != WAIT_RESP))
                proto_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        state     <= ISSUE;
                        owner_lsu <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        if (!ifu_req_valid)
                            starve_cnt <= '0;
                        else if (starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_ifu) begin
                        state      <= ISSUE;
                        owner_lsu  <= 1'b0;
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= {MASK_W{1'b0}};
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready)
                        state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (mem_resp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model,
// with directed phases for starvation order, a stray response and reset mid-transaction.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          proto_err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: where the single transaction is, who owns it, what was latched,
    // and how many LSU grants in a row have passed a waiting IFU.
    typedef enum int {M_FREE, M_OFFERED, M_AWAITING} mphase_t;
    mphase_t       m_phase  = M_FREE;
    bit            m_lsu    = 1'b0;
    int            m_streak = 0;
    bit            m_perr   = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic          m_wen    = 1'b0;
    logic [DW-1:0] m_wdata  = '0;
    logic [MW-1:0] m_wmask  = '0;

    int  resp_q[$];
    byte grants[$];

    // Planned inputs for the next cycle
    logic          n_ifu_v = 1'b0, n_lsu_v = 1'b0, n_lsu_we = 1'b0, n_rst = 1'b1, n_ready = 1'b0;
    logic [AW-1:0] n_ifu_a = '0, n_lsu_a = '0;
    logic [DW-1:0] n_lsu_wd = '0;
    logic [MW-1:0] n_lsu_wm = '0;
    bit            n_stray = 1'b0;

    initial begin
        int  mode;
        bit  g_l, g_i, stray_done, rst_done;
        int  idle_cnt;
        byte exp_seq[6];
        exp_seq = '{"L", "L", "L", "L", "I", "L"};
        mode = 0; stray_done = 0; rst_done = 0; idle_cnt = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst           = n_rst;
            ifu_req_valid = n_ifu_v;  ifu_addr  = n_ifu_a;
            lsu_req_valid = n_lsu_v;  lsu_addr  = n_lsu_a;
            lsu_wen       = n_lsu_we; lsu_wdata = n_lsu_wd; lsu_wmask = n_lsu_wm;
            mem_req_ready = n_ready;
            foreach (resp_q[i]) resp_q[i]--;
            mem_resp_valid = n_stray;
            if (!n_stray && resp_q.size() > 0 && resp_q[0] <= 0) begin
                mem_resp_valid = 1'b1;
                void'(resp_q.pop_front());
            end
            mem_rdata = $urandom;
            n_stray   = 1'b0;

            @(negedge clk);
            if (rst) begin
                m_phase = M_FREE; m_lsu = 0; m_streak = 0; m_perr = 0;
                m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
                check_eq("rst_mem_addr", mem_addr, '0);
                check_eq("rst_mem_wdata", {mem_wen, mem_wdata, mem_wmask}, '0);
            end
            g_l = !rst && m_phase == M_FREE && lsu_req_valid && !(ifu_req_valid && m_streak == LIMIT);
            g_i = !rst && m_phase == M_FREE && ifu_req_valid && !g_l;

            check_eq("ifu_req_ready", ifu_req_ready, g_i);
            check_eq("lsu_req_ready", lsu_req_ready, g_l);
            check_eq("mem_req_valid", mem_req_valid, m_phase == M_OFFERED);
            check_eq("busy", busy, m_phase != M_FREE);
            check_eq("proto_err", proto_err, m_perr);
            check_eq("ifu_resp_valid", ifu_resp_valid, m_phase == M_AWAITING && mem_resp_valid && !m_lsu);
            check_eq("lsu_resp_valid", lsu_resp_valid, m_phase == M_AWAITING && mem_resp_valid && m_lsu);
            if (ifu_resp_valid) check_eq("ifu_rdata", ifu_rdata, mem_rdata);
            if (lsu_resp_valid) check_eq("lsu_rdata", lsu_rdata, mem_rdata);
            if (m_phase == M_OFFERED) begin
                check_eq("mem_addr", mem_addr, m_addr);
                check_eq("mem_wen", mem_wen, m_wen);
                check_eq("mem_wdata", mem_wdata, m_wdata);
                check_eq("mem_wmask", mem_wmask, m_wmask);
            end

            if (!rst) begin
                if (mem_resp_valid && m_phase != M_AWAITING) m_perr = 1;
                case (m_phase)
                    M_FREE: begin
                        if (g_l) begin
                            m_phase = M_OFFERED; m_lsu = 1;
                            m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                            m_streak = ifu_req_valid ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                            grants.push_back("L");
                        end else if (g_i) begin
                            m_phase = M_OFFERED; m_lsu = 0;
                            m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                            m_streak = 0;
                            grants.push_back("I");
                        end
                    end
                    M_OFFERED:  if (mem_req_ready) m_phase = M_AWAITING;
                    default:    if (mem_resp_valid) m_phase = M_FREE;
                endcase
                if (mem_req_valid && mem_req_ready)
                    resp_q.push_back((mode == 1) ? 1 : $urandom_range(1, 3));
            end

            // Phase schedule: reset, starvation run, stray response, then random traffic.
            n_rst = (cyc < 2);
            if (cyc >= 2 && cyc < 45) mode = 1;
            else if (cyc >= 45 && !stray_done) mode = 2;
            else if (stray_done) mode = 0;

            if (cyc == 45) begin
                for (int k = 0; k < 6; k++) begin
                    if (k < grants.size()) check_eq($sformatf("grant_seq_%0d", k), grants[k], exp_seq[k]);
                    else check_eq($sformatf("grant_seq_%0d_missing", k), 0, 1);
                end
            end

            if (mode == 2 && m_phase == M_FREE && resp_q.size() == 0 && !ifu_req_valid && !lsu_req_valid) begin
                idle_cnt++;
                if (idle_cnt == 2) begin
                    n_stray = 1'b1;
                    stray_done = 1;
                end
            end

            if (mode == 0 && !rst_done && cyc > 1500 && m_phase == M_AWAITING && !mem_resp_valid && resp_q.size() > 0) begin
                n_rst = 1'b1;
                rst_done = 1;
            end

            case (mode)
                1: begin
                    n_ifu_v = 1; n_lsu_v = 1; n_ready = 1;
                end
                2: begin
                    n_ifu_v = 0; n_lsu_v = 0; n_ready = 1;
                end
                default: begin
                    n_ready = ($urandom_range(0, 2) != 0);
                    if (g_i || !ifu_req_valid) n_ifu_v = ($urandom_range(0, 2) == 0);
                    else n_ifu_v = ($urandom_range(0, 19) != 0);
                    if (g_l || !lsu_req_valid) n_lsu_v = ($urandom_range(0, 2) == 0);
                    else n_lsu_v = ($urandom_range(0, 19) != 0);
                end
            endcase
            if (g_i || !ifu_req_valid) n_ifu_a = {$urandom} & ~32'h3;
            if (g_l || !lsu_req_valid) begin
                n_lsu_a  = {$urandom} & ~32'h3;
                n_lsu_we = $urandom_range(0, 1);
                n_lsu_wd = $urandom;
                n_lsu_wm = MW'($urandom_range(0, (1 << MW) - 1));
            end
        end

        check_eq("stray_injected", stray_done, 1);
        check_eq("reset_mid_txn_done", rst_done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Takes over the memory-sequencing role of the fixed IF/ID controller, so fetch and data access can be issued on demand from one port.
- Holds one transaction in flight at a time. Each request is registered, issued to memory, and its response is routed back to the requester that owns it.
- LSU has priority. A starvation limit guarantees IFU forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive LSU grants allowed while IFU waits before IFU is forced through (must be ≥1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse).
- ifu_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte write mask.
- lsu_resp_valid  out  1  LSU response valid (1-cycle pulse; also marks write completion).
- lsu_rdata  out  DATA_W  LSU read data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  registered address.
- mem_wen  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_wmask  out  DATA_W/8  registered mask.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- proto_err  out  1  sticky flag: mem_resp_valid seen outside WAIT_RESP.

Behaviour:
- **Reset values.** state = IDLE, owner = IFU, starve_cnt = 0, proto_err = 0. All mem_* request registers are 0. All valid/ready outputs are 0.
- **States.** IDLE, ISSUE, WAIT_RESP.
- **IDLE, grant selection.**
  - Only LSU valid → grant LSU.
  - Only IFU valid → grant IFU.
  - Both valid → grant LSU, unless starve_cnt == STARVE_LIMIT, in which case grant IFU.
- **IDLE, on grant.**
  - Assert the winner's *_req_ready combinationally in the same cycle.
  - Latch addr/wen/wdata/wmask into the mem_* registers. For IFU: wen = 0, wdata = 0, wmask = 0.
  - Set owner and go to ISSUE.
  - *_req_ready is never asserted outside IDLE, and never to both requesters.
- **starve_cnt.**
  - LSU grant while ifu_req_valid = 1 → increment, saturating at STARVE_LIMIT.
  - Any IFU grant → clear to 0.
  - LSU grant with ifu_req_valid = 0 → clear to 0.
- **ISSUE.**
  - mem_req_valid = 1, driven from registers.
  - mem_* stays stable until mem_req_ready.
  - On mem_req_ready → WAIT_RESP.
- **WAIT_RESP.**
  - mem_req_valid = 0.
  - On mem_resp_valid, in the same cycle: owner's *_resp_valid = 1 and owner's *_rdata = mem_rdata (combinational pass-through). Then → IDLE.
  - The non-owner's resp_valid stays 0.
  - rdata outputs equal mem_rdata at all times; only the valid is gated.
- **Minimum latency.** Request accepted at cycle N. mem_req_valid at N+1. If mem_req_ready is high at N+1, response is accepted earliest at N+2. Next grant earliest at N+3.
- **Memory contract.** Memory responds at least one cycle after accepting a request and has at most 1 outstanding.
- **Protocol error.** mem_resp_valid in IDLE or ISSUE is ignored (nothing forwarded) and sets proto_err. proto_err clears only on rst.
- **Requester inputs.** Requesters may drop valid before ready without effect, since nothing is latched.
- **Reset mid-transaction.** Returns immediately to IDLE and the transaction is abandoned. A stale response arriving later sets proto_err.
- **No combinational paths** from mem_req_ready to the requester ready signals.

Test Plan:
- IFU read alone, mem_req_ready = 1, mem_resp_valid 2 cycles after accept with mem_rdata = 0x00000013 → ifu_req_ready at N; mem_req_valid with mem_addr = ifu_addr at N+1; ifu_resp_valid pulse with ifu_rdata = 0x13 at N+3; lsu_resp_valid stays 0.
- LSU write addr 0x80000010, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready held low 3 cycles → mem_* stable 0x80000010 / 0xDEADBEEF / wen = 1 throughout ISSUE; lsu_resp_valid only on mem_resp_valid.
- Both valid continuously, STARVE_LIMIT = 4 → grant order LSU, LSU, LSU, LSU, IFU, LSU…; starve_cnt back to 0 after the IFU grant.
- mem_resp_valid pulsed in IDLE → no resp_valid on either side; proto_err = 1 and stays 1 until rst.
- rst asserted during WAIT_RESP → next cycle busy = 0, all ready/valid = 0, mem_req_valid = 0; a subsequent IFU request completes normally.
